mac_cfg_loader: RTL

Upstream configuration front-end for the quad MAC cluster. Accepts the cluster's wide configuration word (4 initial accumulator values plus mode bits) as a stream of narrow words over a valid/ready handshake and assembles it into a full-width `cfg` bus. When the stream is complete and well-formed, it pulses `cset` for exactly one cycle. It also gates the cluster's `en` so the cluster is stalled while a reconfiguration is in flight.

---
 rtl/mac_cfg_loader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mac_cfg_loader.sv
// -----------------------------------------------------------------------------
// mac_cfg_loader
//
// Configuration front-end for the quad MAC cluster. Collects the cluster's wide
// configuration word (four initial accumulator values plus mode bits) from a
// narrow valid/ready stream, LSB word first, and commits it with a one-cycle
// cset strobe once a correctly framed load has arrived. While a load is in
// flight the cluster enable is gated off so the cluster never runs against a
// half-written cfg.
//
// Ports:
//   clk         clock
//   rst         synchronous, active-high reset
//   load_start  request a new load (only honoured when idle)
//   in_valid    stream word valid
//   in_ready    loader accepts a word (high only while loading)
//   in_data     stream word
//   in_last     marks the final word of a load
//   mac_en_in   user enable for the cluster
//   mac_en      gated enable to the cluster (mac_en_in & ~busy)
//   cfg         assembled configuration bus to the cluster
//   cset        one-cycle commit strobe to the cluster
//   busy        high whenever the loader is not idle
//   done        one-cycle pulse on a successful commit
//   err         one-cycle pulse on a framing error
// -----------------------------------------------------------------------------
module mac_cfg_loader #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int MAC_ACC_WIDTH  = 32,
  parameter int CFG_WIDTH      = 4 * MAC_ACC_WIDTH + MAC_CONF_WIDTH,
  parameter int WORD_WIDTH     = 8,
  parameter int NUM_WORDS      = (CFG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  mac_en_in,
  output logic                  mac_en,
  output logic [CFG_WIDTH-1:0]  cfg,
  output logic                  cset,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]           state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CFG_WIDTH-1:0] cfg_q;
  logic                 cset_q;
  logic                 done_q;
  logic                 err_q;

  logic                 xfer;
  logic                 at_last;
  logic [CFG_WIDTH-1:0] wr_mask;
  logic [CFG_WIDTH-1:0] wr_data;

  // Word placement is done with a shifted mask over the full bus: bits of the
  // final word that fall beyond CFG_WIDTH are simply shifted out of range, so
  // they are dropped without any special-case slice.
  // NOTE: every always_comb output gets a default at the top; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    xfer    = 1'b0;
    at_last = 1'b0;
    wr_mask = '0;
    wr_data = '0;
    xfer    = in_valid && (state_q == LOAD);
    at_last = (cnt_q == LAST_CNT);
    wr_mask = CFG_WIDTH'({WORD_WIDTH{1'b1}}) << (cnt_q * WORD_WIDTH);
    wr_data = CFG_WIDTH'({NUM_WORDS{in_data}});
  end

  // NOTE: state is updated with non-blocking assignments so every flop in
  // this block samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: cfg is a plain register bank, not a memory, so it is reset like
      // any other flop; a reset mid-load leaves the cluster a zero bus.
      state_q <= IDLE;
      cnt_q   <= '0;
      cfg_q   <= '0;
      cset_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared every cycle unless re-armed below.
      cset_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_start) begin
            state_q <= LOAD;
            cnt_q   <= '0;
          end
        end
        LOAD: begin
          if (xfer) begin
            cfg_q <= (cfg_q & ~wr_mask) | (wr_data & wr_mask);
            if (in_last && at_last) begin
              state_q <= COMMIT;
              cset_q  <= 1'b1;
              done_q  <= 1'b1;
            end else if (!in_last && !at_last) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end else begin
              // Framing error: in_last disagrees with the word count. The
              // partial cfg is left in place; without cset it is never used.
              state_q <= IDLE;
              err_q   <= 1'b1;
            end
          end
        end
        COMMIT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q != IDLE);
  // Purely combinational so the enable drops the same cycle busy rises and
  // follows mac_en_in straight through reset.
  assign mac_en   = mac_en_in & ~busy;
  assign cfg      = cfg_q;
  assign cset     = cset_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
